hazard_unit_sb: RTL and testbench
=================================

Name: hazard_unit_sb

Overview:
- Parametrised next-generation hazard unit for the 5-stage MIPS pipeline (F/D/E/M/W).
- Keeps the existing forwarding, load-use and branch-stall functions, with zero-register qualification applied everywhere.
- Adds a single-entry scoreboard for a multi-cycle multiply/divide unit, including write-port arbitration against the W stage.
- Adds saturating stall-cause performance counters.
- Sits between the pipeline registers and the register file.

Parameters:
- RA_W, 5, register address width.
- MD_LATENCY, 4, cycles from MdStartE to the MD result write; legal range 2..15.
- CNT_W, 16, width of each stall counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- rsD, rtD  in  RA_W each  source registers in Decode.
- rsE, rtE  in  RA_W each  source registers in Execute.
- WriteRegE, WriteRegM, WriteRegW  in  RA_W each  destination registers per stage.
- RegWriteE, RegWriteM, RegWriteW  in  1 each  write enables per stage.
- MemtoRegE, MemtoRegM  in  1 each  load in E / M.
- BranchD  in  1  branch in Decode.
- MdStartD  in  1  MD op in Decode.
- MdStartE  in  1  MD op in Execute (launch pulse).
- MdDstE  in  RA_W  MD destination register.
- CntClr  in  1  synchronous clear of all counters.
- ForwardAE, ForwardBE  out  2 each  00 = regfile, 01 = W, 10 = M.
- ForwardAD, ForwardBD  out  1 each  forward M into the branch comparator.
- StallF, StallD, FlushE  out  1 each.
- MdBusy  out  1  MD operation outstanding.
- MdWriteEn  out  1  MD result written to the regfile this cycle.
- MdWriteReg  out  RA_W  MD result destination.
- StallCntLw, StallCntBr, StallCntMd  out  CNT_W each  stall-cycle counts.

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - Clears md_cnt, md_dst and all counters to 0.
  - While reset is high, every output is 0.
- Forwarding (combinational, M has priority over W):
  - ForwardAE = 10 if rsE != 0 && rsE == WriteRegM && RegWriteM.
  - Otherwise ForwardAE = 01 if rsE != 0 && rsE == WriteRegW && RegWriteW.
  - Otherwise ForwardAE = 00.
  - ForwardBE is identical using rtE.
  - ForwardAD = rsD != 0 && rsD == WriteRegM && RegWriteM; ForwardBD is identical using rtD.
- Match functions:
  - srcD(r) = r != 0 && (r == rsD || r == rtD).
- lwstall:
  - MemtoRegE && rtE != 0 && (rsD == rtE || rtD == rtE).
- brstall:
  - BranchD && ((RegWriteE && srcD(WriteRegE)) || (MemtoRegM && srcD(WriteRegM))).
- Scoreboard:
  - md_cnt is a 4-bit register; md_dst is an RA_W register.
  - MdBusy = md_cnt != 0.
  - MdWriteReg = md_dst.
  - MdWriteEn = md_cnt == 1 && !RegWriteW. The W stage owns the single write port.
- Scoreboard next-state, evaluated in priority order:
  - If MdStartE: md_cnt = MD_LATENCY and md_dst = MdDstE. A restart while busy abandons the old op; legal streams never do this.
  - Else if md_cnt == 1 && RegWriteW: hold at 1 and retry next cycle.
  - Else if md_cnt != 0: decrement.
- mdstall:
  - MdBusy && (MdStartD || srcD(md_dst)).
  - Still asserted in the MdWriteEn cycle; released the following cycle.
- Stall outputs:
  - stall = lwstall || brstall || mdstall.
  - StallF = StallD = FlushE = stall.
- Counters:
  - Each counter increments by 1 in every cycle its own cause is true; causes are counted independently and can coincide.
  - Counters saturate at 2^CNT_W - 1.
  - CntClr has priority over increment.
- Latency:
  - All hazard and forwarding outputs are combinational from inputs and state, with zero-cycle latency.
  - Counters update on the clock edge.

Test Plan:
- Forwarding: rsE = 3, WriteRegM = 3, RegWriteM = 1, WriteRegW = 3, RegWriteW = 1 -> ForwardAE = 10. Drop RegWriteM -> ForwardAE = 01. Set rsE = 0 -> ForwardAE = 00.
- Load-use: MemtoRegE = 1, rtE = 8, rsD = 8 -> StallF/StallD/FlushE = 1 for one cycle and StallCntLw = 1. Repeat with rtE = 0 -> no stall.
- Branch: BranchD = 1, RegWriteE = 1, WriteRegE = 5, rtD = 5 -> stall. Next cycle MemtoRegM = 1, WriteRegM = 5 -> stall continues and StallCntBr = 2.
- MD scoreboard (MD_LATENCY = 4): MdStartE with MdDstE = 9 at cycle 0, and rsD = 9 from cycle 1.
  - MdBusy = 1 for cycles 1-4.
  - MdWriteEn = 1 with MdWriteReg = 9 at cycle 4.
  - Stall during cycles 1-4, released at cycle 5.
  - StallCntMd = 4.
- Port conflict: same setup plus RegWriteW = 1 at cycle 4 -> MdWriteEn = 0 and md_cnt holds at 1. At cycle 5 with RegWriteW = 0 -> MdWriteEn = 1. Stall is released at cycle 6.
- Reset and saturation (CNT_W = 2):
  - Hold lwstall for 5 cycles -> StallCntLw = 3.
  - Pulse CntClr -> StallCntLw = 0.
  - Assert reset mid-MD-op -> MdBusy, MdWriteEn and stalls go to 0 immediately (asynchronous), with no later MdWriteEn.

Source files
------------

// File: rtl/hazard_unit_sb.sv
// Hazard unit for the 5-stage MIPS pipeline: operand forwarding, load-use and
// branch stalls, a single-entry scoreboard for the multi-cycle multiply/divide
// unit (with write-port arbitration against W), and saturating stall counters.
module hazard_unit_sb #(
  parameter int RA_W       = 5,
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] rsD,
  input  logic [RA_W-1:0] rtD,
  input  logic [RA_W-1:0] rsE,
  input  logic [RA_W-1:0] rtE,
  input  logic [RA_W-1:0] WriteRegE,
  input  logic [RA_W-1:0] WriteRegM,
  input  logic [RA_W-1:0] WriteRegW,
  input  logic            RegWriteE,
  input  logic            RegWriteM,
  input  logic            RegWriteW,
  input  logic            MemtoRegE,
  input  logic            MemtoRegM,
  input  logic            BranchD,
  input  logic            MdStartD,
  input  logic            MdStartE,
  input  logic [RA_W-1:0] MdDstE,
  input  logic            CntClr,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            ForwardAD,
  output logic            ForwardBD,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushE,
  output logic            MdBusy,
  output logic            MdWriteEn,
  output logic [RA_W-1:0] MdWriteReg,
  output logic [CNT_W-1:0] StallCntLw,
  output logic [CNT_W-1:0] StallCntBr,
  output logic [CNT_W-1:0] StallCntMd
);

  localparam logic [3:0]       MD_LAT  = 4'(MD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Scoreboard state: cycles left until the MD result write, and its target.
  logic [3:0]      mdCnt, mdCntNext;
  logic [RA_W-1:0] mdDst, mdDstNext;

  logic [1:0] fwdA, fwdB;
  logic       fwdAD, fwdBD;
  logic       lwStall, brStall, mdStall, stall;
  logic       mdBusy, mdWriteEn;

  // True when a nonzero register r is read by the instruction in Decode.
  function automatic logic srcHit(input logic [RA_W-1:0] r,
                                  input logic [RA_W-1:0] s,
                                  input logic [RA_W-1:0] t);
    return (r != '0) && ((r == s) || (r == t));
  endfunction

  // Execute-stage and Decode-stage forwarding selects; M beats W.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    fwdA = 2'b00;
    fwdB = 2'b00;
    if (rsE != '0 && rsE == WriteRegM && RegWriteM)      fwdA = 2'b10;
    else if (rsE != '0 && rsE == WriteRegW && RegWriteW) fwdA = 2'b01;
    if (rtE != '0 && rtE == WriteRegM && RegWriteM)      fwdB = 2'b10;
    else if (rtE != '0 && rtE == WriteRegW && RegWriteW) fwdB = 2'b01;
    fwdAD = (rsD != '0) && (rsD == WriteRegM) && RegWriteM;
    fwdBD = (rtD != '0) && (rtD == WriteRegM) && RegWriteM;
  end

  // Stall causes: load-use, branch operand not ready, MD result outstanding.
  always_comb begin
    lwStall   = MemtoRegE && (rtE != '0) && ((rsD == rtE) || (rtD == rtE));
    brStall   = BranchD && ((RegWriteE && srcHit(WriteRegE, rsD, rtD)) ||
                            (MemtoRegM && srcHit(WriteRegM, rsD, rtD)));
    mdBusy    = (mdCnt != 4'd0);
    // W owns the single register-file write port; the MD result waits for a free slot.
    mdWriteEn = (mdCnt == 4'd1) && !RegWriteW;
    mdStall   = mdBusy && (MdStartD || srcHit(mdDst, rsD, rtD));
    stall     = lwStall || brStall || mdStall;
  end

  // Scoreboard next state: launch, hold on port conflict, or count down.
  always_comb begin
    mdCntNext = mdCnt;
    mdDstNext = mdDst;
    if (MdStartE) begin
      // A launch while busy silently replaces the outstanding op.
      mdCntNext = MD_LAT;
      mdDstNext = MdDstE;
    end else if (mdCnt == 4'd1 && RegWriteW) begin
      mdCntNext = mdCnt;
    end else if (mdCnt != 4'd0) begin
      mdCntNext = mdCnt - 4'd1;
    end
  end

  // Scoreboard registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    if (reset) begin
      mdCnt <= 4'd0;
      mdDst <= '0;
    end else begin
      mdCnt <= mdCntNext;
      mdDst <= mdDstNext;
    end
  end

  // Saturating per-cause stall counters; clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCntLw <= '0;
      StallCntBr <= '0;
      StallCntMd <= '0;
    end else if (CntClr) begin
      StallCntLw <= '0;
      StallCntBr <= '0;
      StallCntMd <= '0;
    end else begin
      if (lwStall && StallCntLw != CNT_MAX) StallCntLw <= StallCntLw + 1'b1;
      if (brStall && StallCntBr != CNT_MAX) StallCntBr <= StallCntBr + 1'b1;
      if (mdStall && StallCntMd != CNT_MAX) StallCntMd <= StallCntMd + 1'b1;
    end
  end

  // Combinational outputs are forced low while reset is held.
  always_comb begin
    ForwardAE  = reset ? 2'b00 : fwdA;
    ForwardBE  = reset ? 2'b00 : fwdB;
    ForwardAD  = !reset && fwdAD;
    ForwardBD  = !reset && fwdBD;
    StallF     = !reset && stall;
    StallD     = !reset && stall;
    FlushE     = !reset && stall;
    MdBusy     = !reset && mdBusy;
    MdWriteEn  = !reset && mdWriteEn;
    MdWriteReg = reset ? '0 : mdDst;
  end

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Self-checking bench for hazard_unit_sb: directed scenarios plus a randomized
// run against a behavioural model. A second instance with 2-bit counters
// exercises saturation.
module tb_hazard_unit_sb;

  localparam int RA_W   = 5;
  localparam int MD_LAT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [RA_W-1:0] rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW, MdDstE;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic BranchD, MdStartD, MdStartE, CntClr;

  logic [1:0] ForwardAE, ForwardBE;
  logic ForwardAD, ForwardBD, StallF, StallD, FlushE, MdBusy, MdWriteEn;
  logic [RA_W-1:0] MdWriteReg;
  logic [15:0] StallCntLw, StallCntBr, StallCntMd;

  logic [1:0] sForwardAE, sForwardBE;
  logic sForwardAD, sForwardBD, sStallF, sStallD, sFlushE, sMdBusy, sMdWriteEn;
  logic [RA_W-1:0] sMdWriteReg;
  logic [1:0] sStallCntLw, sStallCntBr, sStallCntMd;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: unbounded counts, saturated when compared.
  int mMdCnt, mMdDst, mLw, mBr, mMd;

  always #5 clk = ~clk;

  hazard_unit_sb #(.RA_W(RA_W), .MD_LATENCY(MD_LAT), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .MdStartD(MdStartD), .MdStartE(MdStartE), .MdDstE(MdDstE), .CntClr(CntClr),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD),
    .ForwardBD(ForwardBD), .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .MdBusy(MdBusy), .MdWriteEn(MdWriteEn), .MdWriteReg(MdWriteReg),
    .StallCntLw(StallCntLw), .StallCntBr(StallCntBr), .StallCntMd(StallCntMd)
  );

  hazard_unit_sb #(.RA_W(RA_W), .MD_LATENCY(MD_LAT), .CNT_W(2)) dutSat (
    .clk(clk), .reset(reset), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .MdStartD(MdStartD), .MdStartE(MdStartE), .MdDstE(MdDstE), .CntClr(CntClr),
    .ForwardAE(sForwardAE), .ForwardBE(sForwardBE), .ForwardAD(sForwardAD),
    .ForwardBD(sForwardBD), .StallF(sStallF), .StallD(sStallD), .FlushE(sFlushE),
    .MdBusy(sMdBusy), .MdWriteEn(sMdWriteEn), .MdWriteReg(sMdWriteReg),
    .StallCntLw(sStallCntLw), .StallCntBr(sStallCntBr), .StallCntMd(sStallCntMd)
  );

  // Everything observable from both instances, packed for whole-state comparison.
  function automatic logic [69:0] observed();
    return {ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, FlushE,
            MdBusy, MdWriteEn, MdWriteReg, StallCntLw, StallCntBr, StallCntMd,
            sStallCntLw, sStallCntBr, sStallCntMd};
  endfunction

  // ---------------- reference model ----------------
  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic bit readInD(input int r);
    return r != 0 && (r == int'(rsD) || r == int'(rtD));
  endfunction

  function automatic logic [1:0] fwdSel(input int r);
    if (r != 0 && RegWriteM && r == int'(WriteRegM)) return 2'b10;
    if (r != 0 && RegWriteW && r == int'(WriteRegW)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit causeLw();
    return MemtoRegE && rtE != 0 && (rsD == rtE || rtD == rtE);
  endfunction

  function automatic bit causeBr();
    return BranchD && ((RegWriteE && readInD(int'(WriteRegE))) ||
                       (MemtoRegM && readInD(int'(WriteRegM))));
  endfunction

  function automatic bit causeMd();
    return mMdCnt > 0 && (MdStartD || readInD(mMdDst));
  endfunction

  function automatic logic [69:0] expected();
    bit st;
    bit busy;
    bit wen;
    st   = causeLw() || causeBr() || causeMd();
    busy = mMdCnt > 0;
    wen  = mMdCnt == 1 && !RegWriteW;
    return {fwdSel(int'(rsE)), fwdSel(int'(rtE)),
            1'(readInD(0) || (rsD != 0 && RegWriteM && rsD == WriteRegM)),
            1'(rtD != 0 && RegWriteM && rtD == WriteRegM),
            st, st, st, busy, wen, 5'(mMdDst),
            16'(sat(mLw, 65535)), 16'(sat(mBr, 65535)), 16'(sat(mMd, 65535)),
            2'(sat(mLw, 3)), 2'(sat(mBr, 3)), 2'(sat(mMd, 3))};
  endfunction

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    bit lw, br, md;
    lw = causeLw();
    br = causeBr();
    md = causeMd();
    if (CntClr) begin
      mLw = 0; mBr = 0; mMd = 0;
    end else begin
      mLw += int'(lw); mBr += int'(br); mMd += int'(md);
    end
    if (MdStartE) begin
      mMdCnt = MD_LAT;
      mMdDst = int'(MdDstE);
    end else if (mMdCnt == 1 && RegWriteW) begin
      mMdCnt = 1;
    end else if (mMdCnt > 0) begin
      mMdCnt--;
    end
  endtask

  task automatic model_reset();
    mMdCnt = 0; mMdDst = 0; mLw = 0; mBr = 0; mMd = 0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_idle();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0; MdDstE = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemtoRegE = 1'b0; MemtoRegM = 1'b0; BranchD = 1'b0;
    MdStartD = 1'b0; MdStartE = 1'b0; CntClr = 1'b0;
  endtask

  // Move to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counters();
    set_idle();
    CntClr = 1'b1;
    tick();
    CntClr = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_idle();
    reset = 1'b1;
    rsE = 5'd3; WriteRegM = 5'd3; RegWriteM = 1'b1; rsD = 5'd3;
    MemtoRegE = 1'b1; rtE = 5'd3;
    #2;
    checks++;
    if (observed() !== 70'd0) begin
      $display("FAIL reset_outputs got=%h want=0", observed());
      errors++;
    end
    tick();
    reset = 1'b0;
    set_idle();
    #1;
  endtask

  task automatic test_forwarding();
    set_idle();
    rsE = 5'd3; rtE = 5'd3; rsD = 5'd3;
    WriteRegM = 5'd3; RegWriteM = 1'b1; WriteRegW = 5'd3; RegWriteW = 1'b1;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE, ForwardAD} !== 5'b10_10_1) begin
      $display("FAIL fwd_m got=%b want=10101", {ForwardAE, ForwardBE, ForwardAD});
      errors++;
    end
    RegWriteM = 1'b0;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE, ForwardAD} !== 5'b01_01_0) begin
      $display("FAIL fwd_w got=%b want=01010", {ForwardAE, ForwardBE, ForwardAD});
      errors++;
    end
    rsE = 5'd0; WriteRegW = 5'd0;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b00_00) begin
      $display("FAIL fwd_zero got=%b want=0000", {ForwardAE, ForwardBE});
      errors++;
    end
  endtask

  task automatic test_load_use();
    clear_counters();
    MemtoRegE = 1'b1; rtE = 5'd8; rsD = 5'd8;
    #1;
    checks++;
    if ({StallF, StallD, FlushE} !== 3'b111) begin
      $display("FAIL lw_stall got=%b want=111", {StallF, StallD, FlushE});
      errors++;
    end
    tick();
    set_idle();
    #1;
    checks++;
    if ({StallF, StallCntLw} !== {1'b0, 16'd1}) begin
      $display("FAIL lw_count stall=%b cnt=%0d want stall=0 cnt=1", StallF, StallCntLw);
      errors++;
    end
    MemtoRegE = 1'b1; rtE = 5'd0; rsD = 5'd0;
    #1;
    checks++;
    if ({StallF, StallD, FlushE} !== 3'b000) begin
      $display("FAIL lw_zero_reg got=%b want=000", {StallF, StallD, FlushE});
      errors++;
    end
    tick();
    checks++;
    if (StallCntLw !== 16'd1) begin
      $display("FAIL lw_zero_count got=%0d want=1", StallCntLw);
      errors++;
    end
  endtask

  task automatic test_branch();
    clear_counters();
    BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd5; rtD = 5'd5;
    #1;
    checks++;
    if (StallF !== 1'b1) begin
      $display("FAIL br_stall_e got=%b want=1", StallF);
      errors++;
    end
    tick();
    RegWriteE = 1'b0; MemtoRegM = 1'b1; WriteRegM = 5'd5;
    #1;
    checks++;
    if (StallD !== 1'b1) begin
      $display("FAIL br_stall_m got=%b want=1", StallD);
      errors++;
    end
    tick();
    set_idle();
    #1;
    checks++;
    if ({FlushE, StallCntBr} !== {1'b0, 16'd2}) begin
      $display("FAIL br_count stall=%b cnt=%0d want stall=0 cnt=2", FlushE, StallCntBr);
      errors++;
    end
  endtask

  // MD op launched at cycle 0, Decode reads its destination from cycle 1.
  // conflictAt4 makes W claim the write port at cycle 4.
  task automatic run_md(input bit conflictAt4);
    int lastBusy;
    bit expWen;
    clear_counters();
    MdStartE = 1'b1; MdDstE = 5'd9;
    #1;
    checks++;
    if (MdBusy !== 1'b0) begin
      $display("FAIL md_idle got=%b want=0", MdBusy);
      errors++;
    end
    tick();
    MdStartE = 1'b0; MdDstE = 5'd0; rsD = 5'd9;
    lastBusy = conflictAt4 ? 5 : 4;
    for (int c = 1; c <= lastBusy + 1; c++) begin
      RegWriteW = conflictAt4 && (c == 4);
      #1;
      expWen = (c == lastBusy);
      checks++;
      if ({MdBusy, MdWriteEn, StallF, MdWriteReg} !==
          {1'(c <= lastBusy), expWen, 1'(c <= lastBusy), 5'd9}) begin
        $display("FAIL md_cycle%0d conflict=%0d busy/wen/stall/reg got=%b%b%b/%0d want=%b%b%b/9",
                 c, conflictAt4, MdBusy, MdWriteEn, StallF, MdWriteReg,
                 1'(c <= lastBusy), expWen, 1'(c <= lastBusy));
        errors++;
      end
      tick();
    end
    checks++;
    if (StallCntMd !== 16'(lastBusy)) begin
      $display("FAIL md_count conflict=%0d got=%0d want=%0d", conflictAt4, StallCntMd, lastBusy);
      errors++;
    end
    set_idle();
  endtask

  task automatic test_md_scoreboard();
    run_md(1'b0);
  endtask

  task automatic test_port_conflict();
    run_md(1'b1);
  endtask

  task automatic test_saturation();
    clear_counters();
    MemtoRegE = 1'b1; rtE = 5'd8; rsD = 5'd8;
    repeat (5) tick();
    set_idle();
    #1;
    checks++;
    if ({sStallCntLw, StallCntLw} !== {2'd3, 16'd5}) begin
      $display("FAIL sat_lw got narrow=%0d wide=%0d want narrow=3 wide=5", sStallCntLw, StallCntLw);
      errors++;
    end
    CntClr = 1'b1;
    MemtoRegE = 1'b1; rtE = 5'd8; rsD = 5'd8;
    tick();
    set_idle();
    #1;
    checks++;
    if ({sStallCntLw, StallCntLw} !== 18'd0) begin
      $display("FAIL sat_clear got narrow=%0d wide=%0d want 0", sStallCntLw, StallCntLw);
      errors++;
    end
  endtask

  task automatic test_reset_mid_md();
    bit sawActivity;
    set_idle();
    MdStartE = 1'b1; MdDstE = 5'd9;
    tick();
    MdStartE = 1'b0; rsD = 5'd9;
    tick();
    checks++;
    if ({MdBusy, StallF} !== 2'b11) begin
      $display("FAIL mdrst_pre got=%b want=11", {MdBusy, StallF});
      errors++;
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({MdBusy, MdWriteEn, StallF, StallD, FlushE} !== 5'b0 ||
        {sMdBusy, sMdWriteEn, sStallF} !== 3'b0) begin
      $display("FAIL mdrst_async got=%b%b%b%b%b want=00000",
               MdBusy, MdWriteEn, StallF, StallD, FlushE);
      errors++;
    end
    tick();
    #2 reset = 1'b0;
    sawActivity = 1'b0;
    repeat (MD_LAT + 3) begin
      tick();
      if (MdWriteEn || MdBusy || StallF) sawActivity = 1'b1;
    end
    checks++;
    if (sawActivity !== 1'b0) begin
      $display("FAIL mdrst_after got activity=%b want=0", sawActivity);
      errors++;
    end
    set_idle();
  endtask

  task automatic test_random();
    logic [69:0] exp;
    set_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      rsD       = 5'($urandom_range(0, 3));
      rtD       = 5'($urandom_range(0, 3));
      rsE       = 5'($urandom_range(0, 3));
      rtE       = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3));
      WriteRegM = 5'($urandom_range(0, 3));
      WriteRegW = 5'($urandom_range(0, 3));
      MdDstE    = 5'($urandom_range(0, 3));
      RegWriteE = 1'($urandom_range(0, 1));
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = ($urandom_range(0, 2) == 0);
      MemtoRegE = ($urandom_range(0, 3) == 0);
      MemtoRegM = ($urandom_range(0, 3) == 0);
      BranchD   = ($urandom_range(0, 2) == 0);
      MdStartD  = ($urandom_range(0, 5) == 0);
      MdStartE  = ($urandom_range(0, 9) == 0);
      CntClr    = ($urandom_range(0, 63) == 0);
      #1;
      exp = expected();
      checks++;
      if (observed() !== exp) begin
        $display("FAIL random_cycle%0d got=%h want=%h", n, observed(), exp);
        errors++;
      end
      @(posedge clk);
      model_edge();
      #1;
    end
    set_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    set_idle();
    model_reset();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_md_scoreboard();
    test_port_conflict();
    test_saturation();
    test_reset_mid_md();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
